// File: rtl/fxp_pkg.sv
// ============================================================================
// Module : fxp_pkg
// Brief  : Shared fixed-point constants and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fxp_pkg;

  localparam int C_FXP_WIDTH = 8;
  localparam int C_FXP_FRAC  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fxp_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_fxp_mult_if.sv
// ============================================================================
// Module : seq_fxp_mult_if
// Brief  : Operand/result valid-ready bundle for the sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_fxp_mult_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, ovf
  );

endinterface

`default_nettype wire

// File: rtl/fxp_sat_trunc.sv
// ============================================================================
// Module : fxp_sat_trunc
// Brief  : Formats a double-width unsigned product into Q format with
//          truncation of low fraction bits and saturation on overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fxp_sat_trunc #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  wire logic [2*WIDTH-1:0] full,
  output logic      [WIDTH-1:0]   p,
  output logic                    ovf
);

  // Fraction bits below FRAC are intentionally discarded (no rounding).
  logic w_unused_frac;
  assign w_unused_frac = &{1'b0, full[FRAC-1:0]};

  assign ovf = |full[2*WIDTH-1:WIDTH+FRAC];
  assign p   = ovf ? {WIDTH{1'b1}} : full[FRAC+WIDTH-1:FRAC];

endmodule

`default_nettype wire

// File: rtl/seq_fxp_mult.sv
// ============================================================================
// Module : seq_fxp_mult
// Brief  : Iterative shift-add unsigned Q-format multiplier, WIDTH cycles
//          per product, one operation in flight, valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_fxp_mult
  import fxp_pkg::*;
#(
  parameter int WIDTH = C_FXP_WIDTH,
  parameter int FRAC  = C_FXP_FRAC
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  seq_fxp_mult_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  fxp_state_e r_state;
  fxp_state_e w_state_next;

  logic [2*WIDTH-1:0] r_a_sh;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_b_sh;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_p;
  logic               r_ovf;
  logic [WIDTH-1:0]   w_p;
  logic               w_ovf;
  logic               w_last;

  assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : {2*WIDTH{1'b0}});
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_state_next = ST_CALC;
      ST_CALC: if (w_last)       w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_p    <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a_sh <= {{WIDTH{1'b0}}, bus.a};
            r_b_sh <= bus.b;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        ST_CALC: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
          // Format from the post-add value so the final iteration is included.
          if (w_last) begin
            r_p   <= w_p;
            r_ovf <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  fxp_sat_trunc #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sat_trunc (
    .full (w_acc_next),
    .p    (w_p),
    .ovf  (w_ovf)
  );

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.p         = r_p;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_fxp_mult.sv
// ============================================================================
// Module : tb_seq_fxp_mult
// Brief  : Self-checking bench for seq_fxp_mult against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_fxp_mult;

  localparam int W = 8;
  localparam int F = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  seq_fxp_mult_if #(.WIDTH(W)) bus ();

  seq_fxp_mult #(.WIDTH(W), .FRAC(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: exact integer product, then Q4.4 truncation / saturation.
  function automatic void ref_mult(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] p, output logic ovf);
    int full;
    full = int'(a) * int'(b);
    ovf  = (full >= 4096);
    p    = ovf ? 8'hFF : 8'((full / 16) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands in IDLE, lets one edge accept them, then waits
  // (bounded) for out_valid, returning the edges counted after acceptance.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.p !== 8'h00) begin bad++; $display("FAIL reset_p got=%h want=00", bus.p); end
    total++;
    if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] ta [6] = '{8'h20, 8'h08, 8'h18, 8'hF0, 8'h01, 8'hFF};
    logic [7:0] tb [6] = '{8'h30, 8'h80, 8'h28, 8'h20, 8'h01, 8'hFF};
    logic [7:0] ep;
    logic       eo;
    int         lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ref_mult(ta[i], tb[i], ep, eo);
      issue(ta[i], tb[i], lat);
      total++;
      if (lat !== W) begin bad++; $display("FAIL latency[%0d] got=%0d want=%0d", i, lat, W); end
      total++;
      if (bus.p !== ep) begin bad++; $display("FAIL prod[%0d] %h*%h got=%h want=%h", i, ta[i], tb[i], bus.p, ep); end
      total++;
      if (bus.ovf !== eo) begin bad++; $display("FAIL ovf[%0d] got=%b want=%b", i, bus.ovf, eo); end
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL done_one_cycle[%0d] out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b, ep;
    logic       eo;
    int         lat;
    a = 8'($urandom_range(1, 63));
    b = 8'($urandom_range(1, 63));
    ref_mult(a, b, ep, eo);
    bus.out_ready = 1'b0;
    issue(a, b, lat);
    total++;
    if (lat !== W) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, W); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = ~a;
      bus.b        = ~b;
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.p !== ep || bus.ovf !== eo) begin
        bad++;
        $display("FAIL bp_hold[%0d] valid=%b ready=%b p=%h ovf=%b want 1/0/%h/%b",
                 i, bus.out_valid, bus.in_ready, bus.p, bus.ovf, ep, eo);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.out_ready = 1'b1;
    bus.a         = 8'h20;
    bus.b         = 8'h30;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.p !== 8'h00 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset valid=%b p=%h ovf=%b ready=%b want 0/00/0/1",
               bus.out_valid, bus.p, bus.ovf, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'h20, 8'h30, lat);
    total++;
    if (lat !== W || bus.p !== 8'h60 || bus.ovf !== 1'b0) begin
      bad++; $display("FAIL after_reset lat=%0d p=%h ovf=%b want %0d/60/0", lat, bus.p, bus.ovf, W);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, ep;
    logic       eo;
    int         prev_acc;
    int         acc_cyc;
    int         waited;
    bus.out_ready = 1'b1;
    prev_acc      = -1;
    for (int i = 0; i < 10; i++) begin
      waited = 0;
      while (!bus.in_ready && waited < 40) begin tick(); waited++; end
      a = 8'($urandom);
      b = 8'($urandom);
      ref_mult(a, b, ep, eo);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick();
      acc_cyc = cyc;
      bus.a   = 8'($urandom);
      bus.b   = 8'($urandom);
      if (prev_acc >= 0) begin
        total++;
        if (acc_cyc - prev_acc !== W + 2) begin
          bad++; $display("FAIL b2b_interval[%0d] got=%0d want=%0d", i, acc_cyc - prev_acc, W + 2);
        end
      end
      prev_acc = acc_cyc;
      waited = 0;
      while (!bus.out_valid && waited < 40) begin tick(); waited++; end
      total++;
      if (bus.out_valid !== 1'b1 || bus.p !== ep || bus.ovf !== eo) begin
        bad++;
        $display("FAIL b2b[%0d] %h*%h valid=%b p=%h ovf=%b want 1/%h/%b",
                 i, a, b, bus.out_valid, bus.p, bus.ovf, ep, eo);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
